// File: rtl/load_wb_stage_pkg.sv
// Shared definitions for the load writeback stage: widths, mode fields,
// size codes, read-data state encoding and the MEM-to-WB bundle layout.
package load_wb_stage_pkg;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW_RF  = 5;
    localparam int unsigned MODE_W = 6;

    localparam int unsigned MODE_LOAD  = 5;
    localparam int unsigned MODE_STORE = 4;
    localparam int unsigned MODE_SEXT  = 0;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam logic [2:0] SZ_LWL  = 3'b011;
    localparam logic [2:0] SZ_LWR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [DW-1:0]     pc;
        logic [MODE_W-1:0] mode;
        logic [DW-1:0]     result;
        logic [DW-1:0]     rt_val;
        logic [AW_RF-1:0]  dest;
        logic              gr_we;
    } ws_bundle_t;

endpackage

// File: rtl/load_wb_stage_if.sv
// MEM-to-WB handshake and instruction bundle; master is the MEM stage.
interface load_wb_stage_if;
    import load_wb_stage_pkg::*;

    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [DW-1:0]     ms_pc;
    logic [MODE_W-1:0] ms_mode;
    logic [DW-1:0]     ms_result;
    logic [DW-1:0]     ms_rt_val;
    logic [AW_RF-1:0]  ms_dest;
    logic              ms_gr_we;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_mode, ms_result, ms_rt_val, ms_dest, ms_gr_we,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_mode, ms_result, ms_rt_val, ms_dest, ms_gr_we,
        output ws_allowin
    );

endinterface

// File: rtl/load_wb_stage_align.sv
// Little-endian load alignment: byte/half extension, word pass-through and
// LWL/LWR merge with the old rt value. mode is {size[2:0], sext}.
module load_align
    import load_wb_stage_pkg::*;
(
    input  logic [3:0]    mode,
    input  logic [1:0]    lo,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] rt_val,
    output logic [DW-1:0] aligned_c
);

    logic [2:0]  size;
    logic        sext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size     = mode[3:1];
    assign sext     = mode[MODE_SEXT];
    assign byte_sel = rdata[{lo, 3'b000} +: 8];
    assign half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        aligned_c = rdata;
        case (size)
            SZ_BYTE: aligned_c = {{24{sext & byte_sel[7]}}, byte_sel};
            SZ_HALF: aligned_c = {{16{sext & half_sel[15]}}, half_sel};
            SZ_WORD: aligned_c = rdata;
            SZ_LWL: begin
                case (lo)
                    2'd0: aligned_c = {rdata[7:0],  rt_val[23:0]};
                    2'd1: aligned_c = {rdata[15:0], rt_val[15:0]};
                    2'd2: aligned_c = {rdata[23:0], rt_val[7:0]};
                    2'd3: aligned_c = rdata;
                endcase
            end
            SZ_LWR: begin
                case (lo)
                    2'd0: aligned_c = rdata;
                    2'd1: aligned_c = {rt_val[31:24], rdata[31:8]};
                    2'd2: aligned_c = {rt_val[31:16], rdata[31:16]};
                    2'd3: aligned_c = {rt_val[31:8],  rdata[31:24]};
                endcase
            end
            default: aligned_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_wb_stage.sv
// Writeback stage: latches the MEM bundle, keeps SRAM read data alive across
// commit stalls, aligns loads and drives RF write, trace and forwarding.
module load_wb_stage
    import load_wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    load_wb_stage_if.slave       ms,
    input  logic [DW-1:0]        data_sram_rdata,
    input  logic                 commit_ready,
    output logic                 rf_we,
    output logic [AW_RF-1:0]     rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [DW-1:0]        debug_wb_pc,
    output logic [3:0]           debug_wb_rf_wen,
    output logic [AW_RF-1:0]     debug_wb_rf_wnum,
    output logic [DW-1:0]        debug_wb_rf_wdata,
    output logic                 ws_fwd_valid,
    output logic [AW_RF-1:0]     ws_fwd_dest,
    output logic [DW-1:0]        ws_fwd_data
);

    logic          ws_valid;
    ws_bundle_t    ws_r;
    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          buf_load;
    logic [DW-1:0] rdata_buf;
    logic [DW-1:0] rdata_eff;
    logic [DW-1:0] aligned_c;
    logic [DW-1:0] final_data;
    logic          accept;
    logic          ws_writes;
    logic          is_load;

    assign ms.ws_allowin = !ws_valid | commit_ready;
    assign accept        = ms.ms_to_ws_valid & ms.ws_allowin;

    // Stage valid and instruction bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ws_r     <= '0;
        end else begin
            if (ms.ws_allowin) ws_valid <= ms.ms_to_ws_valid;
            if (accept) begin
                ws_r <= '{pc:     ms.ms_pc,
                          mode:   ms.ms_mode,
                          result: ms.ms_result,
                          rt_val: ms.ms_rt_val,
                          dest:   ms.ms_dest,
                          gr_we:  ms.ms_gr_we};
            end
        end
    end

    // Read-data state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // SRAM data is only valid in the cycle after the request, so a stalled
    // FRESH instruction snapshots it before it disappears.
    always_comb begin
        state_nxt = state;
        buf_load  = 1'b0;
        if (accept) begin
            state_nxt = FRESH;
        end else begin
            case (state)
                FRESH: begin
                    if (commit_ready) state_nxt = IDLE;
                    else begin
                        state_nxt = HELD;
                        buf_load  = 1'b1;
                    end
                end
                HELD:    if (commit_ready) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) rdata_buf <= data_sram_rdata;
    end

    assign rdata_eff = (state == HELD) ? rdata_buf : data_sram_rdata;

    load_align u_align (
        .mode      (ws_r.mode[3:0]),
        .lo        (ws_r.result[1:0]),
        .rdata     (rdata_eff),
        .rt_val    (ws_r.rt_val),
        .aligned_c (aligned_c)
    );

    assign is_load    = ws_r.mode[MODE_LOAD] & ~ws_r.mode[MODE_STORE];
    assign final_data = is_load ? aligned_c : ws_r.result;
    assign ws_writes  = ws_valid & ws_r.gr_we & (ws_r.dest != '0);

    assign rf_we             = ws_writes & commit_ready;
    assign rf_waddr          = ws_r.dest;
    assign rf_wdata          = final_data;
    assign debug_wb_pc       = ws_r.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_r.dest;
    assign debug_wb_rf_wdata = final_data;
    assign ws_fwd_valid      = ws_writes;
    assign ws_fwd_dest       = ws_r.dest;
    assign ws_fwd_data       = final_data;

endmodule
